// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared state encoding and selector helper for the APB manager
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DECERR = 2'd3
   } apb_mgr_state_t;

   // One bit of a one-hot selector vector: set when pos matches the index.
   function automatic logic onehot_sel(input int unsigned idx, input int unsigned pos);
      return idx == pos;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_sel_decode.sv
// ============================================================================
// apb_sel_decode : peripheral index -> {valid, one-hot PSEL vector}
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_sel_decode
   import apb_pkg::*;
#(
   parameter int PrphNum = 1,
   parameter int IdxW    = 1
) (
   input  logic [IdxW-1:0]    idx_i,
   output logic               valid_o,
   output logic [PrphNum-1:0] sel_o
);

   always_comb begin
      sel_o   = '0;
      valid_o = 32'(idx_i) < PrphNum;
      for (int i = 0; i < PrphNum; i++) begin
         sel_o[i] = valid_o && onehot_sel(32'(idx_i), i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_manager.sv
// ============================================================================
// apb_manager : GenericBus request -> APB SETUP/ACCESS sequence, with decode
//               error and ACCESS timeout handling. All outputs registered.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_manager
   import apb_pkg::*;
#(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 32,
   parameter int ProtWidth  = 4,
   parameter int PrphNum    = 1,
   parameter int SelLsb     = 8,
   parameter int TimeoutCyc = 16
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic                   sub_wEn,
   input  logic                   sub_rEn,
   input  logic [AddrWidth-1:0]   sub_addr,
   input  logic [DataWidth-1:0]   sub_wData,
   input  logic [DataWidth/8-1:0] sub_wStrb,
   input  logic [ProtWidth-1:0]   sub_prot,
   output logic [DataWidth-1:0]   sub_rData,
   output logic                   sub_error,
   output logic                   sub_busy,
   output logic                   bus_write,
   output logic                   bus_enable,
   output logic [AddrWidth-1:0]   bus_addr,
   output logic [DataWidth-1:0]   bus_wData,
   output logic [DataWidth/8-1:0] bus_strb,
   output logic [ProtWidth-1:0]   bus_prot,
   output logic [PrphNum-1:0]     bus_selectors,
   input  logic [DataWidth-1:0]   bus_rData,
   input  logic                   bus_subError,
   input  logic                   bus_ready
);

   localparam int IDX_W = (PrphNum > 1) ? $clog2(PrphNum) : 1;
   localparam int CNT_W = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TimeoutCyc > 0) ? TimeoutCyc - 1 : 0);

   apb_mgr_state_t         state_q, state_d;
   logic [PrphNum-1:0]     sel_q, sel_d;
   logic                   en_q, en_d;
   logic                   wr_q, wr_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [DataWidth/8-1:0] strb_q, strb_d;
   logic [ProtWidth-1:0]   prot_q, prot_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   dec_valid;
   logic [PrphNum-1:0]     dec_sel;

   apb_sel_decode #(
      .PrphNum (PrphNum),
      .IdxW    (IDX_W)
   ) u_sel_decode (
      .idx_i   (sub_addr[SelLsb +: IDX_W]),
      .valid_o (dec_valid),
      .sel_o   (dec_sel)
   );

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         prot_q  <= prot_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      busy_d  = busy_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sub_wEn || sub_rEn) begin
               busy_d = 1'b1;
               // Out-of-range index never touches the bus; bus fields keep their old values.
               if (dec_valid) begin
                  state_d = SETUP;
                  sel_d   = dec_sel;
                  en_d    = 1'b0;
                  wr_d    = sub_wEn;
                  addr_d  = sub_addr;
                  wdata_d = sub_wData;
                  strb_d  = sub_wEn ? sub_wStrb : '0;
                  prot_d  = sub_prot;
               end else begin
                  state_d = DECERR;
               end
            end
         end
         SETUP: begin
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (bus_ready) begin
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               err_d   = bus_subError;
               if (!wr_q) rdata_d = bus_rData;
               state_d = IDLE;
            end else if ((TimeoutCyc != 0) && (cnt_q == CNT_LAST)) begin
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DECERR: begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sub_rData     = rdata_q;
   assign sub_error     = err_q;
   assign sub_busy      = busy_q;
   assign bus_write     = wr_q;
   assign bus_enable    = en_q;
   assign bus_addr      = addr_q;
   assign bus_wData     = wdata_q;
   assign bus_strb      = strb_q;
   assign bus_prot      = prot_q;
   assign bus_selectors = sel_q;

endmodule

`default_nettype wire
